// File: rtl/tb_min_state_pipe_pkg.sv
// Shared Viterbi selector definitions: default geometry, metric/pair types and a log2 helper.
package vit_pkg;

  localparam int M_DEF           = 3;
  localparam int W_DEF           = 8;
  localparam int NS              = 1 << M_DEF;
  localparam int NORM_THRESH_DEF = 128;

  typedef logic [W_DEF-1:0] metric_t;

  typedef struct packed {
    metric_t            metric;
    logic [M_DEF-1:0]   idx;
  } pair_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tb_min_state_pipe_if.sv
// Beat-in / result-out handshake bundle between the ACS array, the selector and traceback.
interface tb_min_state_pipe_if #(
  parameter int M = 3,
  parameter int W = 8
);
  localparam int NSTATE = 1 << M;

  logic                  in_valid;
  logic                  in_ready;
  logic [NSTATE*W-1:0]   in_metrics;
  logic                  out_valid;
  logic                  out_ready;
  logic [M-1:0]          best_state;
  logic [W-1:0]          min_metric;
  logic                  norm_req;

  modport master (
    output in_valid, in_metrics, out_ready,
    input  in_ready, out_valid, best_state, min_metric, norm_req
  );

  modport slave (
    input  in_valid, in_metrics, out_ready,
    output in_ready, out_valid, best_state, min_metric, norm_req
  );
endinterface

// File: rtl/tb_min_state_pipe_node.sv
// Combinational 2:1 (metric,index) select; the left (lower-index) operand wins ties.
module tb_min_node #(
  parameter int M = 3,
  parameter int W = 8
) (
  input  logic [W-1:0] a_metric,
  input  logic [M-1:0] a_idx,
  input  logic [W-1:0] b_metric,
  input  logic [M-1:0] b_idx,
  output logic [W-1:0] y_metric,
  output logic [M-1:0] y_idx
);

  logic a_wins;

  assign a_wins   = (a_metric <= b_metric);
  assign y_metric = a_wins ? a_metric : b_metric;
  assign y_idx    = a_wins ? a_idx    : b_idx;

endmodule

// File: rtl/tb_min_state_pipe.sv
// Pipelined minimum-metric state selector: binary compare tree, one register level per
// tree level, global-enable stall so every stage holds while the result is not taken.
module tb_min_state_pipe
  import vit_pkg::*;
#(
  parameter int M           = M_DEF,
  parameter int W           = W_DEF,
  parameter int NORM_THRESH = NORM_THRESH_DEF
) (
  input logic               clk,
  input logic               reset,
  tb_min_state_pipe_if.slave bus
);

  localparam int NSTATE = 1 << M;

  typedef struct packed {
    logic [W-1:0] metric;
    logic [M-1:0] idx;
  } node_t;

  // Tree stored heap-style: node j compares children 2j and 2j+1; j >= NSTATE are the leaves.
  node_t leaf [NSTATE];
  node_t win  [1:NSTATE-1];
  node_t q    [1:NSTATE-1];

  logic [M:1] vld_p;
  logic [M:0] stage_vld;
  logic       norm_p;
  logic       stall;

  function automatic logic norm_hit(input logic [W-1:0] m);
    return int'({1'b0, m}) >= NORM_THRESH;
  endfunction

  assign stall         = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign stage_vld     = {vld_p, bus.in_valid};
  assign bus.out_valid = stage_vld[M];

  for (genvar s = 0; s < NSTATE; s++) begin : g_leaf
    assign leaf[s] = {bus.in_metrics[s*W +: W], M'(s)};
  end

  for (genvar j = 1; j < NSTATE; j++) begin : g_node
    node_t a, b, y;
    if (2*j >= NSTATE) begin : g_from_leaf
      assign a = leaf[2*j - NSTATE];
      assign b = leaf[2*j + 1 - NSTATE];
    end else begin : g_from_reg
      assign a = q[2*j];
      assign b = q[2*j + 1];
    end
    tb_min_node #(.M(M), .W(W)) u_node (
      .a_metric (a.metric),
      .a_idx    (a.idx),
      .b_metric (b.metric),
      .b_idx    (b.idx),
      .y_metric (y.metric),
      .y_idx    (y.idx)
    );
    assign win[j] = y;
  end

  // Stage valids: reset discards every in-flight beat and overrides a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else if (!stall) begin
      for (int k = 1; k <= M; k++) vld_p[k] <= stage_vld[k-1];
    end
  end

  // Inner levels load freely (bubble data is don't-care); the root only on a valid beat.
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int j = 2; j < NSTATE; j++) q[j] <= win[j];
    end
    if (reset) begin
      q[1]   <= '0;
      norm_p <= 1'b0;
    end else if (!stall && stage_vld[M-1]) begin
      q[1]   <= win[1];
      norm_p <= norm_hit(win[1].metric);
    end
  end

  assign bus.best_state = q[1].idx;
  assign bus.min_metric = q[1].metric;
  assign bus.norm_req   = norm_p;

endmodule

// File: tb/tb_tb_min_state_pipe.sv
// Directed bench for the minimum-state selector: M=3 main instance plus M=1 / M=5 sweeps.
module tb_tb_min_state_pipe;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tb_min_state_pipe_if #(.M(3), .W(8)) if3 ();
  tb_min_state_pipe_if #(.M(1), .W(8)) if1 ();
  tb_min_state_pipe_if #(.M(5), .W(8)) if5 ();

  tb_min_state_pipe #(.M(3), .W(8), .NORM_THRESH(128)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));
  tb_min_state_pipe #(.M(1), .W(8), .NORM_THRESH(128)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  tb_min_state_pipe #(.M(5), .W(8), .NORM_THRESH(128)) u5 (.clk(clk), .reset(reset), .bus(if5.slave));

  typedef struct { int best; int mn; int nrm; } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] min_at(input int pos);
    logic [63:0] r;
    for (int s = 0; s < 8; s++) r[s*8 +: 8] = (s == pos) ? 8'd5 : 8'd9;
    return r;
  endfunction

  // One isolated beat on the M=3 instance: latency, result, then hold across the bubble.
  task automatic run_one(input string tag, input logic [63:0] mets, input int eb, input int em, input int en);
    if3.in_valid   = 1'b1;
    if3.in_metrics = mets;
    if3.out_ready  = 1'b1;
    #2;
    check({tag, ".rdy"}, 32'(if3.in_ready), 1);
    tick();
    if3.in_valid = 1'b0;
    check({tag, ".v1"}, 32'(if3.out_valid), 0);
    tick();
    check({tag, ".v2"}, 32'(if3.out_valid), 0);
    tick();
    check({tag, ".v3"}, 32'(if3.out_valid), 1);
    check({tag, ".best"}, 32'(if3.best_state), eb);
    check({tag, ".min"}, 32'(if3.min_metric), em);
    check({tag, ".norm"}, 32'(if3.norm_req), en);
    tick();
    check({tag, ".bubble"}, 32'(if3.out_valid), 0);
    check({tag, ".hold"}, 32'(if3.best_state), eb);
  endtask

  task automatic sweep(input int m);
    int   ns, sent, got, acc_c, vis_c, b;
    logic [255:0] pk;
    int   mv [32];
    logic iv, orr, ov, ir, nr;
    int   bs, mn;
    exp_t eq [$];
    exp_t e, r;
    bit   need_new;
    ns = 1 << m; sent = 0; got = 0; acc_c = -1; vis_c = -1; need_new = 1'b1;
    pk = '0;
    for (int c = 0; c < 400 && got < 24; c++) begin
      if (need_new && sent < 24) begin
        case ($urandom_range(0, 2))
          0:       b = 0;
          1:       b = 120;
          default: b = 200;
        endcase
        pk = '0;
        for (int s = 0; s < ns; s++) begin
          mv[s] = b + int'($urandom_range(0, 7));
          pk[s*8 +: 8] = 8'(mv[s]);
        end
        r.best = 0;
        for (int s = 1; s < ns; s++) if (mv[s] < mv[r.best]) r.best = s;
        r.mn  = mv[r.best];
        r.nrm = (r.mn >= 128) ? 1 : 0;
        need_new = 1'b0;
      end
      iv  = (sent < 24);
      orr = (c < 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (m == 1) begin
        if1.in_valid = iv; if1.in_metrics = pk[15:0]; if1.out_ready = orr;
      end else begin
        if5.in_valid = iv; if5.in_metrics = pk; if5.out_ready = orr;
      end
      #2;
      ov = (m == 1) ? if1.out_valid : if5.out_valid;
      ir = (m == 1) ? if1.in_ready  : if5.in_ready;
      bs = (m == 1) ? int'(if1.best_state) : int'(if5.best_state);
      mn = (m == 1) ? int'(if1.min_metric) : int'(if5.min_metric);
      nr = (m == 1) ? if1.norm_req  : if5.norm_req;
      if (ov && vis_c < 0) vis_c = c;
      if (ov && orr) begin
        if (eq.size() == 0) begin
          check($sformatf("m%0d.spurious", m), 32'(ov), 0);
        end else begin
          e = eq.pop_front();
          check($sformatf("m%0d.best%0d", m, got), 32'(bs), e.best);
          check($sformatf("m%0d.min%0d", m, got), 32'(mn), e.mn);
          check($sformatf("m%0d.norm%0d", m, got), 32'(nr), e.nrm);
        end
        got++;
      end
      if (iv && ir) begin
        eq.push_back(r);
        if (acc_c < 0) acc_c = c;
        sent++;
        need_new = 1'b1;
      end
      tick();
    end
    if1.in_valid = 1'b0; if1.out_ready = 1'b1;
    if5.in_valid = 1'b0; if5.out_ready = 1'b1;
    check($sformatf("m%0d.count", m), 32'(got), 24);
    check($sformatf("m%0d.latency", m), 32'(vis_c - acc_c), m);
  endtask

  initial begin
    int nxt, rcv;
    logic acc;
    reset = 1'b1;
    if3.in_valid = 1'b0; if3.in_metrics = '0; if3.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_metrics = '0; if1.out_ready = 1'b1;
    if5.in_valid = 1'b0; if5.in_metrics = '0; if5.out_ready = 1'b1;
    tick();
    tick();
    check("rst.vld", 32'(if3.out_valid), 0);
    check("rst.best", 32'(if3.best_state), 0);
    check("rst.min", 32'(if3.min_metric), 0);
    check("rst.norm", 32'(if3.norm_req), 0);
    check("rst.vld1", 32'(if1.out_valid), 0);
    check("rst.vld5", 32'(if5.out_valid), 0);
    reset = 1'b0;
    #1;
    check("rst.rdy", 32'(if3.in_ready), 1);

    // Single beats: first minimum wins ties; norm threshold on both sides of 128.
    run_one("t1", {8'd80, 8'd33, 8'd17, 8'd60, 8'd17, 8'd90, 8'd22, 8'd40}, 3, 17, 0);
    run_one("t2a", {8{8'd200}}, 0, 200, 1);
    run_one("t2b", {8'd127, {7{8'd255}}}, 7, 127, 0);
    run_one("t2c", {8'd130, 8'd130, 8'd130, 8'd128, 8'd130, 8'd130, 8'd130, 8'd130}, 4, 128, 1);
    run_one("t2d", {8{8'd255}}, 0, 255, 1);

    // Back-to-back stream, minimum walking through s0..s7.
    for (int c = 0; c < 11; c++) begin
      if3.in_valid   = (c < 8);
      if3.in_metrics = min_at(c % 8);
      #2;
      if (c >= 3) begin
        check($sformatf("t3.vld%0d", c), 32'(if3.out_valid), 1);
        check($sformatf("t3.best%0d", c), 32'(if3.best_state), c - 3);
        check($sformatf("t3.min%0d", c), 32'(if3.min_metric), 5);
      end
      tick();
    end
    if3.in_valid = 1'b0;

    // Downstream stall for 4 cycles while streaming 8 beats.
    nxt = 0; rcv = 0;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      if3.out_ready  = !(c >= 3 && c <= 6);
      if3.in_valid   = (nxt < 8);
      if3.in_metrics = min_at(nxt % 8);
      #2;
      if (c >= 3 && c <= 6) begin
        check($sformatf("t4.svld%0d", c), 32'(if3.out_valid), 1);
        check($sformatf("t4.srdy%0d", c), 32'(if3.in_ready), 0);
        check($sformatf("t4.shold%0d", c), 32'(if3.best_state), 0);
      end
      if (if3.out_valid && if3.out_ready) begin
        check($sformatf("t4.order%0d", rcv), 32'(if3.best_state), rcv);
        check($sformatf("t4.min%0d", rcv), 32'(if3.min_metric), 5);
        rcv++;
      end
      acc = if3.in_valid && if3.in_ready;
      tick();
      if (acc) nxt++;
    end
    if3.in_valid = 1'b0;
    if3.out_ready = 1'b1;
    check("t4.count", 32'(rcv), 8);
    tick();
    check("t4.nodup", 32'(if3.out_valid), 0);

    // Reset with two beats in flight: neither may appear.
    if3.in_valid = 1'b1; if3.in_metrics = min_at(1);
    tick();
    if3.in_metrics = min_at(2);
    tick();
    if3.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5.rbest", 32'(if3.best_state), 0);
    check("t5.rmin", 32'(if3.min_metric), 0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("t5.vld%0d", c), 32'(if3.out_valid), 0);
      tick();
    end
    run_one("t5", min_at(6), 6, 5, 0);

    sweep(1);
    sweep(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
